// File: rtl/pg_alu_seq.sv
// Power-gated sequential ALU: power/isolation sequencer, single-cycle ALU ops,
// iterative shift-add multiply, and an output clamp while isolated or unpowered.
module pg_alu_seq #(
   parameter int unsigned      WIDTH         = 16,
   parameter logic [WIDTH-1:0] CLAMP_VAL     = WIDTH'(1),
   parameter int unsigned      PWR_UP_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwr_req,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       opcode,
   input  logic             start,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic             start_err,
   output logic [WIDTH-1:0] result,
   output logic             alu_pwr_en,
   output logic             iso_en,
   output logic [2:0]       pwr_state
);

   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned CW  = $clog2(WIDTH + PWR_UP_CYCLES + 1);

   typedef enum logic [2:0] {
      S_OFF     = 3'd0,
      S_PWR_UP  = 3'd1,
      S_ISO_REL = 3'd2,
      S_ON_IDLE = 3'd3,
      S_EXEC    = 3'd4,
      S_ISO_SET = 3'd5,
      S_PWR_DN  = 3'd6
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] op_a_q, op_b_q, acc_q, res_q;
   logic [3:0]       op_q;
   logic             done_q;
   logic [WIDTH-1:0] alu_val, mul_step, exec_val;
   logic             exec_last;

   always_comb begin
      alu_val = '0;
      case (op_q)
         4'd0: alu_val = op_a_q + op_b_q;
         4'd1: alu_val = op_a_q - op_b_q;
         4'd2: alu_val = op_a_q & op_b_q;
         4'd3: alu_val = op_a_q | op_b_q;
         4'd4: alu_val = op_a_q ^ op_b_q;
         4'd5: alu_val = ~op_a_q;
         4'd6: alu_val = op_a_q << op_b_q[SHW-1:0];
         4'd7: alu_val = op_a_q >> op_b_q[SHW-1:0];
         default: alu_val = '0;
      endcase
      // MUL consumes op_a_q/op_b_q as the shifting multiplicand/multiplier
      mul_step  = op_b_q[0] ? op_a_q : '0;
      exec_last = (op_q != 4'd8) || (cnt_q == CW'(WIDTH - 1));
      exec_val  = (op_q == 4'd8) ? acc_q + mul_step : alu_val;
   end

   always_comb begin
      state_d    = state_q;
      ready      = 1'b0;
      busy       = 1'b0;
      alu_pwr_en = 1'b0;
      iso_en     = 1'b1;
      case (state_q)
         S_OFF: if (pwr_req) state_d = S_PWR_UP;
         S_PWR_UP: begin
            alu_pwr_en = 1'b1;
            if (cnt_q == CW'(PWR_UP_CYCLES - 1)) state_d = S_ISO_REL;
         end
         S_ISO_REL: begin
            alu_pwr_en = 1'b1;
            iso_en     = 1'b0;
            state_d    = S_ON_IDLE;
         end
         S_ON_IDLE: begin
            alu_pwr_en = 1'b1;
            iso_en     = 1'b0;
            ready      = 1'b1;
            if (start)         state_d = S_EXEC;
            else if (!pwr_req) state_d = S_ISO_SET;
         end
         S_EXEC: begin
            alu_pwr_en = 1'b1;
            iso_en     = 1'b0;
            busy       = 1'b1;
            if (exec_last) state_d = S_ON_IDLE;
         end
         S_ISO_SET: begin
            alu_pwr_en = 1'b1;
            state_d    = S_PWR_DN;
         end
         S_PWR_DN: state_d = S_OFF;
         default:  state_d = S_OFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_OFF;
         cnt_q   <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         op_q    <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         case (state_q)
            S_OFF: cnt_q <= '0;
            S_PWR_UP: begin
               cnt_q  <= cnt_q + CW'(1);
               op_a_q <= '0;
               op_b_q <= '0;
               op_q   <= '0;
               acc_q  <= '0;
               res_q  <= '0;
            end
            S_ON_IDLE: begin
               if (start) begin
                  op_a_q <= a;
                  op_b_q <= b;
                  op_q   <= opcode;
                  acc_q  <= '0;
                  cnt_q  <= '0;
               end
            end
            S_EXEC: begin
               if (exec_last) begin
                  res_q  <= exec_val;
                  done_q <= 1'b1;
               end else begin
                  acc_q  <= acc_q + mul_step;
                  op_a_q <= op_a_q << 1;
                  op_b_q <= op_b_q >> 1;
                  cnt_q  <= cnt_q + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign done      = done_q;
   assign start_err = start & ~ready;
   assign result    = (iso_en || !alu_pwr_en) ? CLAMP_VAL : res_q;
   assign pwr_state = state_q;

endmodule
